// File: rtl/karatsuba_mul_seq.sv
// Sequential Karatsuba multiplier: three partial products share one S x S multiplier, then recombine.
// Optional two's-complement operation is enabled by defining KARATSUBA_SEQ_SIGNED_EN.
module karatsuba_mul_seq #(
  parameter int N = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   u,
  input  logic [N-1:0]   v,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] r
);
  // Handshake: a transfer happens on a rising edge where valid && ready are both 1.
  // in_ready is 1 only while idle; r/out_valid hold steady until out_ready is seen.
  localparam int H = N / 2 + N % 2;
  localparam int L = N - H;
  localparam int S = H + 1;
  localparam int W = 2 * N;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_X   = 3'd1,
    MUL_Y   = 3'd2,
    MUL_Z   = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t state;

  logic [S-1:0]   a_q, b_q, c_q, d_q, sa_q, sc_q;
  logic [2*S-1:0] x_q, y_q, z_q;

  logic [N-1:0]   mag_u, mag_v;
  logic [S-1:0]   a_n, b_n, c_n, d_n;
  logic [S-1:0]   mul_a, mul_b;
  logic [2*S-1:0] mul_p;
  logic [W-1:0]   x_w, y_w, z_w, mid_w, prod, res;

`ifdef KARATSUBA_SEQ_SIGNED_EN
  logic sign_q;
  logic sign_n;

  always_comb begin
    mag_u  = u[N-1] ? -u : u;
    mag_v  = v[N-1] ? -v : v;
    sign_n = u[N-1] ^ v[N-1];
  end
`else
  always_comb begin
    mag_u = u;
    mag_v = v;
  end
`endif

  always_comb begin
    a_n = {{(S-L){1'b0}}, mag_u[N-1:H]};
    b_n = {1'b0, mag_u[H-1:0]};
    c_n = {{(S-L){1'b0}}, mag_v[N-1:H]};
    d_n = {1'b0, mag_v[H-1:0]};
  end

  // Single shared multiplier; its operands follow the current partial-product state.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      MUL_X: begin
        mul_a = a_q;
        mul_b = c_q;
      end
      MUL_Y: begin
        mul_a = b_q;
        mul_b = d_q;
      end
      MUL_Z: begin
        mul_a = sa_q;
        mul_b = sc_q;
      end
      default: begin
        mul_a = '0;
        mul_b = '0;
      end
    endcase
    mul_p = {{S{1'b0}}, mul_a} * {{S{1'b0}}, mul_b};
  end

  // Recombination wraps modulo 2^(2N); the low 2N bits equal those of the wider sum.
  always_comb begin
    x_w   = {{(W-2*S){1'b0}}, x_q};
    y_w   = {{(W-2*S){1'b0}}, y_q};
    z_w   = {{(W-2*S){1'b0}}, z_q};
    mid_w = z_w - x_w - y_w;
    prod  = (x_w << (2 * H)) + (mid_w << H) + y_w;
`ifdef KARATSUBA_SEQ_SIGNED_EN
    res   = sign_q ? -prod : prod;
`else
    res   = prod;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      r         <= '0;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      d_q       <= '0;
      sa_q      <= '0;
      sc_q      <= '0;
      x_q       <= '0;
      y_q       <= '0;
      z_q       <= '0;
`ifdef KARATSUBA_SEQ_SIGNED_EN
      sign_q    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_q      <= a_n;
            b_q      <= b_n;
            c_q      <= c_n;
            d_q      <= d_n;
            sa_q     <= a_n + b_n;
            sc_q     <= c_n + d_n;
`ifdef KARATSUBA_SEQ_SIGNED_EN
            sign_q   <= sign_n;
`endif
            in_ready <= 1'b0;
            state    <= MUL_X;
          end
        end
        MUL_X: begin
          x_q   <= mul_p;
          state <= MUL_Y;
        end
        MUL_Y: begin
          y_q   <= mul_p;
          state <= MUL_Z;
        end
        MUL_Z: begin
          z_q   <= mul_p;
          state <= COMBINE;
        end
        COMBINE: begin
          r         <= res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_karatsuba_mul_seq.sv
// Bench for karatsuba_mul_seq: N=16 instance under a cycle model, plus an N=7 odd-width instance.
module tb_karatsuba_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] u, v;
  logic [31:0] r;

  logic        in_valid7, in_ready7, out_valid7;
  logic [6:0]  u7, v7;
  logic [13:0] r7;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  karatsuba_mul_seq #(.N(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .u(u), .v(v), .out_valid(out_valid), .out_ready(out_ready), .r(r)
  );

  karatsuba_mul_seq #(.N(7)) dut7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid7), .in_ready(in_ready7),
    .u(u7), .v(v7), .out_valid(out_valid7), .out_ready(1'b1), .r(r7)
  );

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b);
`ifdef KARATSUBA_SEQ_SIGNED_EN
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {16'h0, a} * {16'h0, b};
`endif
  endfunction

  function automatic logic [13:0] model7(input logic [6:0] a, input logic [6:0] b);
`ifdef KARATSUBA_SEQ_SIGNED_EN
    logic signed [13:0] p;
    p = $signed(a) * $signed(b);
    return p;
`else
    return {7'h0, a} * {7'h0, b};
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle model of the N=16 block: busy from acceptance until the output handshake,
  // result visible from the 4th edge after acceptance.
  bit          m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_prod = '0;
  bit          exp_ov;

  initial forever begin
    @(negedge clk);
    exp_ov = m_busy && (m_cnt >= 4);
    check("cyc_out_valid", out_valid, exp_ov);
    check("cyc_in_ready", in_ready, !m_busy);
    if (exp_ov) check("cyc_r", r, m_prod);
    if (!rst_n) begin
      m_busy = 1'b0;
    end else if (!m_busy) begin
      if (in_valid) begin
        m_busy = 1'b1;
        m_cnt  = 0;
        m_prod = model16(u, v);
      end
    end else if (exp_ov && out_ready) begin
      m_busy = 1'b0;
    end else if (m_cnt < 4) begin
      m_cnt++;
    end
  end

  task automatic send16(input logic [15:0] a, input logic [15:0] b);
    bit ok = 1'b0;
    @(posedge clk); #1;
    u = a; v = b; in_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept16", ok, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out16(output logic [31:0] res);
    bit ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    check("out_wait16", ok, 1'b1);
    res = r;
    @(posedge clk); #1;
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] lit, input string name);
    logic [31:0] res;
    check({name, "_model"}, model16(a, b), lit);
    send16(a, b);
    wait_out16(res);
    check(name, res, lit);
  endtask

  task automatic run7(input logic [6:0] a, input logic [6:0] b,
                      input logic [13:0] lit, input string name);
    bit ok = 1'b0;
    int lat = -1;
    check({name, "_model"}, model7(a, b), lit);
    @(posedge clk); #1;
    u7 = a; v7 = b; in_valid7 = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready7) begin
        ok = 1'b1;
        break;
      end
    end
    check({name, "_accept"}, ok, 1'b1);
    @(posedge clk); #1;
    in_valid7 = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_valid7) begin
        lat = i;
        break;
      end
    end
    check({name, "_latency"}, lat, 4);
    check(name, r7, lit);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] res, held;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; u = '0; v = '0;
    in_valid7 = 1'b0; u7 = '0; v7 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_r", r, 32'h0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_in_ready7", in_ready7, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run16(16'h04D2, 16'h162E, 32'h006AE9BC, "mul_1234_5678");
`ifdef KARATSUBA_SEQ_SIGNED_EN
    run16(16'hFFFF, 16'hFFFF, 32'h00000001, "ffff_sq");
    run16(16'h0000, 16'hFFFF, 32'h00000000, "zero_x");
    run16(16'h8000, 16'h8000, 32'h40000000, "min_sq");
    run16(16'hFFFF, 16'h0001, 32'hFFFFFFFF, "neg1_x1");
    run16(16'hFFFD, 16'h0007, 32'hFFFFFFEB, "neg3_x7");
    run7(7'd127, 7'd127, 14'h0001, "n7_max_sq");
    run7(7'd64, 7'd3, 14'h3F40, "n7_64x3");
`else
    run16(16'hFFFF, 16'hFFFF, 32'hFFFE0001, "ffff_sq");
    run16(16'h0000, 16'hFFFF, 32'h00000000, "zero_x");
    run16(16'h8000, 16'h8000, 32'h40000000, "min_sq");
    run16(16'hFFFF, 16'h0001, 32'h0000FFFF, "neg1_x1");
    run16(16'hFFFD, 16'h0007, 32'h0006FFEB, "neg3_x7");
    run7(7'd127, 7'd127, 14'h3F01, "n7_max_sq");
    run7(7'd64, 7'd3, 14'h00C0, "n7_64x3");
`endif
    run16(16'h00FF, 16'h0100, 32'h0000FF00, "halves");

    // Backpressure: hold out_ready low, poke in_valid, result must not move.
    out_ready = 1'b0;
    send16(16'h1234, 16'h5678);
    wait_out16(held);
    check("bp_first", held, model16(16'h1234, 16'h5678));
    for (int i = 0; i < 10; i++) begin
      u = 16'(i * 4099); v = 16'(i * 257 + 1); in_valid = i[0];
      @(negedge clk);
      check("bp_r_stable", r, held);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_out_valid", out_valid, 1'b1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; in_valid = 1'b1; u = 16'd7; v = 16'd9;
    @(negedge clk);
    check("bp_pre_hs_in_ready", in_ready, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_idle_after_hs", in_ready, 1'b1);
    check("bp_valid_dropped", out_valid, 1'b0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_accepted_next", in_ready, 1'b0);
    wait_out16(res);
    check("bp_next_result", res, 32'd63);

    // Reset while the block is in MUL_Y.
    send16(16'h00FF, 16'h0101);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_r", r, 32'h0);
    check("midrst_in_ready", in_ready, 1'b1);
    run16(16'd3, 16'd5, 32'd15, "after_rst_3x5");
    repeat (8) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/karatsuba_mul_seq.md
# karatsuba_mul_seq

Sequential, parametrised Karatsuba multiplier: splits each N-bit operand into high/low halves and evaluates the three partial products (x = a·c, y = b·d, z = (a+b)·(c+d)) on one shared sub-multiplier over three cycles, then recombines. It is the area-reduced, handshaked successor to the combinational Karatsuba node. It sits between a valid/ready producer and consumer, and trades throughput for one-third of the multiplier area.

## Interface
- N, default 16: operand width; legal range N ≥ 4, odd values allowed.
- Derived (localparam): H = N/2 + N%2 (low-half width); L = N − H (high-half width); S = H + 1 (shared sub-multiplier operand width).
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands u, v valid.
- in_ready  out  1  block can accept operands.
- u  in  N  multiplicand.
- v  in  N  multiplier.
- out_valid  out  1  r holds a finished product.
- out_ready  in  1  consumer accepts r.
- r  out  2N  product u·v.

## Operation
- Input handshake: the block accepts operands on a rising edge where in_valid && in_ready. At acceptance it registers:
  - a = u[N−1:H], b = u[H−1:0], c = v[N−1:H], d = v[H−1:0];
  - sa = a + b and sc = c + d, each S bits wide and zero-extended.
- FSM states: IDLE → MUL_X → MUL_Y → MUL_Z → COMBINE → DONE → IDLE.
  - IDLE: in_ready = 1; on acceptance, go to MUL_X.
  - MUL_X: shared multiplier operands are {a, c}, zero-extended to S bits; x_reg (2S bits) is captured at the end of the state.
  - MUL_Y: operands {b, d}; y_reg is captured.
  - MUL_Z: operands {sa, sc}; z_reg is captured.
  - COMBINE: computes r = (x << 2H) + ((z − x − y) << H) + y, evaluated at 2N+2 bits and truncated to 2N. z − x − y ≥ 0 always; no borrow handling is needed. r and out_valid = 1 are registered at the end of the state.
  - DONE: r and out_valid are held until out_ready = 1, then the block goes to IDLE.
- in_ready = 1 only in IDLE. Operands presented in any other state are ignored, and no buffering is done.
- One shared multiplier of S×S → 2S bits, combinational, with its operands driven through a state-selected mux.
- Reset (rst_n = 0 on an edge):
  - state = IDLE, out_valid = 0, r = 0, all internal registers = 0.
  - in_ready reads 1 after the reset edge.
  - A product in flight is discarded; no out_valid is produced for it.
- Simultaneous in_valid and out_valid in DONE: no acceptance happens, because in_ready = 0.

## Timing
- Acceptance edge = edge k. Captures: x at edge k+1, y at edge k+2, z at edge k+3. r and out_valid are set at edge k+4.
- Latency: out_valid is visible in the cycle after edge k+4, i.e. 4 edges after acceptance.
- Output handshake at edge m returns the block to IDLE at edge m. The earliest next acceptance is edge m+1.
- Max throughput: 1 product per 6 cycles with out_ready held at 1.
- r is stable and unchanged for the whole time out_valid = 1.

## Configuration
- Macro KARATSUBA_SEQ_SIGNED_EN.
- Defined: u and v are two's complement.
  - At acceptance the block stores |u|, |v| (N-bit unsigned) and sign = u[N−1] ^ v[N−1].
  - |−2^(N−1)| = 2^(N−1) fits in N bits unsigned.
  - COMBINE outputs the negated magnitude when sign = 1, giving a 2N-bit two's-complement r.
  - Latency is unchanged.
- Undefined: unsigned operation only; no sign logic is synthesised.

## Test plan
- N=16, unsigned: u=0x04D2, v=0x162E (1234·5678) -> r=0x006AE9BC. out_valid rises exactly 4 edges after acceptance.
- N=16, unsigned: u=v=0xFFFF -> r=0xFFFE0001. Then u=0, v=0xFFFF -> r=0.
- N=7 (odd width): u=v=127 -> r=0x3F01. u=64, v=3 -> r=0x00C0.
- Backpressure, N=16:
  - out_ready is held 0 for 10 cycles after out_valid.
  - Required: r is stable, in_ready = 0, and in_valid pulses are ignored.
  - out_ready = 1 -> block is in IDLE the next cycle, and the next operands are accepted one edge later.
- Reset mid-op, N=16: assert rst_n = 0 during MUL_Y -> the next cycle shows out_valid = 0, r = 0, in_ready = 1. A fresh 3·5 then yields r = 15 with no stale result.
- KARATSUBA_SEQ_SIGNED_EN defined, N=16:
  - 0x8000·0x8000 -> r=0x40000000;
  - 0xFFFF·0x0001 -> r=0xFFFFFFFF;
  - 0xFFFD·0x0007 -> r=0xFFFFFFEB.
